// File: rtl/bash_hash_params_pkg.sv
// bash_hash_params_pkg: shared Bash hash constants, rate table and padding FSM states
package bash_hash_params_pkg;
  localparam int BASH_BLK_W = 1024;
  localparam logic [5:0] RATE_W_L128 = 6'd32;
  localparam logic [5:0] RATE_W_L192 = 6'd24;
  localparam logic [5:0] RATE_W_L256 = 6'd16;
  localparam logic [7:0] PAD_BYTE = 8'h40;
  typedef enum logic [1:0] {IDLE, FILL, PAD, EMIT} state_t;
  function automatic logic [5:0] rate_words(input logic [8:0] l);
    return l == 9'd128 ? RATE_W_L128 : l == 9'd192 ? RATE_W_L192 : RATE_W_L256;
  endfunction
endpackage

// File: rtl/bash_msg_pad.sv
// bash_msg_pad: packs message words into Bash rate blocks and appends the 0x40 pad byte
module bash_msg_pad
  import bash_hash_params_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BLK_W = BASH_BLK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [8:0]       l_i,
  input  logic [XLEN-1:0]  s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  input  logic [2:0]       s_bytes_i,
  output logic             s_ready_o,
  output logic [BLK_W-1:0] blk_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i
);
  localparam int NW = BLK_W / XLEN;
  localparam int CW = $clog2(NW);
  localparam int NB = XLEN / 8;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_words [NW];
  logic [CW-1:0] r_cnt;
  logic [8:0] r_l;
  logic r_last, r_pad_next;
  logic [5:0] w_rate;
  logic [2:0] w_b;
  logic w_acc, w_full, w_b4;
  logic [XLEN-1:0] w_word;
  assign w_rate = rate_words(r_l);
  assign w_acc  = r_state == FILL && s_valid_i;
  assign w_full = 6'(r_cnt) == w_rate - 6'd1;
  assign w_b    = !s_last_i || s_bytes_i > 3'd4 ? 3'd4 : s_bytes_i;
  assign w_b4   = w_b == 3'd4;
  // Bytes past the valid count are zeroed; on a short last word the pad lands right after the data
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NB; k++)
      w_word[8*k +: 8] = 3'(k) < w_b ? s_data_i[8*k +: 8] : (s_last_i && 3'(k) == w_b ? PAD_BYTE : 8'h00);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start_i ? FILL : IDLE;
      FILL:    w_next = w_acc && (s_last_i || w_full) ? EMIT : FILL;
      PAD:     w_next = EMIT;
      EMIT:    w_next = !m_ready_i ? EMIT : r_last ? IDLE : r_pad_next ? PAD : FILL;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    s_ready_o = r_state == FILL;
    m_valid_o = r_state == EMIT;
    m_last_o  = r_state == EMIT && r_last;
  end
  // A full last word that also completes the block defers its pad to a separate PAD block
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) r_words[i] <= '0;
      r_cnt      <= '0;
      r_l        <= 9'd256;
      r_last     <= 1'b0;
      r_pad_next <= 1'b0;
    end else begin
      if (r_state == IDLE && start_i) begin
        for (int i = 0; i < NW; i++) r_words[i] <= '0;
        r_cnt      <= '0;
        r_l        <= l_i;
        r_last     <= 1'b0;
        r_pad_next <= 1'b0;
      end
      if (w_acc) begin
        r_words[r_cnt] <= w_word;
        r_cnt          <= r_cnt + 1'b1;
        if (s_last_i && w_b4 && !w_full) r_words[r_cnt + 1'b1] <= XLEN'(PAD_BYTE);
        r_last     <= s_last_i && !(w_b4 && w_full);
        r_pad_next <= s_last_i && w_b4 && w_full;
      end
      if (r_state == PAD) begin
        r_words[0] <= XLEN'(PAD_BYTE);
        r_last     <= 1'b1;
        r_pad_next <= 1'b0;
      end
      if (r_state == EMIT && m_ready_i) begin
        for (int i = 0; i < NW; i++) r_words[i] <= '0;
        r_cnt  <= '0;
        r_last <= 1'b0;
      end
    end
  for (genvar g = 0; g < NW; g++) begin : g_blk
    assign blk_o[g*XLEN +: XLEN] = r_words[g];
  end
endmodule

// File: tb/tb_bash_msg_pad.sv
// tb_bash_msg_pad: random and directed messages checked against a byte-stream padding model
module tb_bash_msg_pad;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [8:0] l_i = '0;
  logic [31:0] s_data_i = '0;
  logic s_valid_i = 1'b0, s_last_i = 1'b0;
  logic [2:0] s_bytes_i = '0;
  logic s_ready_o, m_valid_o, m_last_o;
  logic m_ready_i = 1'b0;
  logic [1023:0] blk_o;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  bash_msg_pad dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .l_i(l_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_bytes_i(s_bytes_i),
    .s_ready_o(s_ready_o), .blk_o(blk_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
    .m_ready_i(m_ready_i)
  );

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int rate_of(input logic [8:0] l);
    return l == 9'd128 ? 32 : l == 9'd192 ? 24 : 16;
  endfunction

  // Message of nw beats whose last beat carries b bytes; the expected output is the byte stream
  // msg || 0x40 zero-filled to whole rate blocks.
  task automatic send_msg(input logic [8:0] l, input int nw, input int b, input int stall, input bit noisy);
    logic [7:0] msg[$];
    logic [7:0] st[$];
    logic [1023:0] exp_q[$];
    bit last_q[$];
    logic [1023:0] bl;
    int rb, nbytes, nblk, wi, cyc, stalls, idx;
    rb = rate_of(l) * 4;
    nbytes = (nw - 1) * 4 + b;
    for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    st = msg;
    st.push_back(8'h40);
    while (st.size() % rb != 0) st.push_back(8'h00);
    nblk = st.size() / rb;
    for (int k = 0; k < nblk; k++) begin
      bl = '0;
      for (int j = 0; j < rb; j++) bl[8*j +: 8] = st[k*rb + j];
      exp_q.push_back(bl);
      last_q.push_back(k == nblk - 1);
    end
    @(negedge clk);
    l_i = l;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    l_i = 9'($urandom);
    wi = 0;
    cyc = 0;
    stalls = stall;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (m_valid_o) begin
        chkb("s_ready_in_emit", s_ready_o, 1'b0);
        chk("blk", blk_o, exp_q[0]);
        chkb("m_last", m_last_o, last_q[0]);
      end
      m_ready_i = (m_valid_o && stalls > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (m_valid_o && stalls > 0) stalls--;
      if (m_valid_o && m_ready_i) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      if (wi < nw) begin
        s_valid_i = $urandom_range(0, 3) != 0;
        for (int k = 0; k < 4; k++) begin
          idx = wi * 4 + k;
          s_data_i[8*k +: 8] = idx < nbytes ? msg[idx] : 8'($urandom);
        end
        s_last_i = wi == nw - 1;
        s_bytes_i = !s_last_i ? 3'($urandom) : (b == 4 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(5, 7)) : 3'(b);
        if (s_valid_i && s_ready_o) wi++;
      end else begin
        s_valid_i = 1'b0;
      end
      if (noisy) begin
        start_i = $urandom_range(0, 7) == 0;
        l_i = 9'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    m_ready_i = 1'b0;
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    chkb("all_blocks_seen", exp_q.size() == 0, 1'b1);
    @(negedge clk);
    chkb("idle_valid", m_valid_o, 1'b0);
    chkb("idle_ready", s_ready_o, 1'b0);
  endtask

  initial begin
    logic [8:0] rl;
    #1;
    chkb("rst_s_ready", s_ready_o, 1'b0);
    chkb("rst_m_valid", m_valid_o, 1'b0);
    chkb("rst_m_last", m_last_o, 1'b0);
    chk("rst_blk", blk_o, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_msg(9'd256, 1, 0, 0, 1'b0);
    send_msg(9'd128, 1, 3, 0, 1'b0);
    send_msg(9'd256, 16, 4, 0, 1'b0);
    send_msg(9'd192, 24, 4, 5, 1'b0);
    send_msg(9'd128, 33, 4, 0, 1'b0);
    @(negedge clk);
    l_i = 9'd128;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1;
      s_last_i = 1'b0;
      s_data_i = $urandom;
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chkb("arst_s_ready", s_ready_o, 1'b0);
    chkb("arst_m_valid", m_valid_o, 1'b0);
    chkb("arst_m_last", m_last_o, 1'b0);
    chk("arst_blk", blk_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    send_msg(9'd128, 1, 3, 0, 1'b0);
    for (int t = 0; t < 15; t++) begin
      case ($urandom_range(0, 3))
        0: rl = 9'd128;
        1: rl = 9'd192;
        2: rl = 9'd256;
        default: rl = 9'($urandom);
      endcase
      send_msg(rl, $urandom_range(1, 40), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bash_msg_pad.md
BASH_MSG_PAD -- requirements
Module: bash_msg_pad

Interface
REQ-001 SHALL have parameter XLEN, default 32, input word width in bits.
REQ-002 SHALL have parameter BLK_W, default 1024, output block width (maximum rate, ℓ=128).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse that begins a new message and samples l_i.
REQ-006 SHALL have port l_i  input  9  security level ℓ: 128, 192 or 256.
REQ-007 SHALL have port s_data_i  input  XLEN  message word; byte k at bits [8k+7:8k].
REQ-008 SHALL have port s_valid_i  input  1  message word valid.
REQ-009 SHALL have port s_last_i  input  1  final word of the message.
REQ-010 SHALL have port s_bytes_i  input  3  valid bytes in the last word (0..4); ignored when s_last_i=0.
REQ-011 SHALL have port s_ready_o  output  1  word accepted when s_valid_i&s_ready_o.
REQ-012 SHALL have port blk_o  output  BLK_W  padded rate block for Bash-F absorb; byte k at bits [8k+7:8k].
REQ-013 SHALL have port m_valid_o  output  1  blk_o valid.
REQ-014 SHALL have port m_last_o  output  1  blk_o is the final (padded) block.
REQ-015 SHALL have port m_ready_i  input  1  downstream accepts block when m_valid_o&m_ready_i.

Function
REQ-016 SHALL derive rate words R (32-bit) from latched ℓ: 128->32, 192->24, any other value->16.
REQ-017 SHALL implement FSM states IDLE, FILL, PAD, EMIT.
REQ-018 IDLE: s_ready_o=0, m_valid_o=0; start_i -> latch ℓ, clear block and word counter, go to FILL; start_i in any other state SHALL be ignored.
REQ-019 FILL: s_ready_o=1; each accepted non-last word SHALL be written at word index cnt, cnt increments; sustained throughput one word/cycle.
REQ-020 FILL, accepted non-last word with cnt reaching R -> EMIT with m_last_o=0; m_valid_o asserts the next cycle.
REQ-021 FILL, accepted last word with s_bytes_i=b: write bytes 0..b-1, byte b of that word (or byte 0 of the next word if b=4) SHALL be 0x40, remaining block bytes 0; -> EMIT with m_last_o=1.
REQ-022 Exception: last word with b=4 completing the block (cnt reaches R) -> EMIT with m_last_o=0, then PAD.
REQ-023 PAD: s_ready_o=0; build block with byte 0 = 0x40, all else 0; next cycle -> EMIT with m_last_o=1.
REQ-024 EMIT: s_ready_o=0; blk_o, m_last_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-025 EMIT handshake: if m_last_o=0 -> clear block, cnt=0, return to FILL (or PAD per REQ-022); if m_last_o=1 -> IDLE.
REQ-026 Bits of blk_o at and above R*32 SHALL always be 0.
REQ-027 Non-last words SHALL always carry 4 bytes; s_bytes_i>4 on a last word SHALL be treated as 4.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, blk_o=0, cnt=0, latched ℓ=256, s_ready_o=0, m_valid_o=0, m_last_o=0, including mid-FILL/EMIT; partial message is discarded.

Structure
REQ-029 Rate word counts, BLK_W and the FSM state enum SHALL reside in bash_hash_params_pkg; pad byte 0x40 as a named package constant.
REQ-030 SHALL be a single module; no sub-module is required.

Verification
REQ-031 ℓ=256, start, one beat last=1 bytes=0 -> one block, blk_o[7:0]=0x40, rest 0, m_last_o=1.
REQ-032 ℓ=128, one beat 0x00CCBBAA last=1 bytes=3 -> blk_o[31:0]=0x40CCBBAA, bits [1023:32]=0, m_last_o=1.
REQ-033 ℓ=256, 16 full words, last on word 16 -> block 1 (m_last_o=0, words 0..15 = data), then block 2 blk_o[7:0]=0x40, m_last_o=1.
REQ-034 ℓ=192, 24 words, m_ready_i low 5 cycles -> blk_o stable, s_ready_o=0 throughout; bits [1023:768]=0.
REQ-035 ℓ=128, 33 full words last on 33rd -> block 1 32 words m_last_o=0; block 2 word0=data, blk_o[39:32]=0x40, m_last_o=1.
REQ-036 rst_n pulsed low after 5 words in FILL -> all outputs 0 immediately, IDLE; new start yields clean block without stale data.
